// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared encodings for the character position store: step
//                directions, character ids, default reset coordinates and
//                the scan FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  // Step direction encodings; bit 0 set means "increment" on either axis
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Character ids; pacman is always entry 0
  localparam int CHAR_PACMAN = 0;
  localparam int CHAR_GHOST1 = 1;
  localparam int CHAR_GHOST2 = 2;
  localparam int CHAR_GHOST3 = 3;
  localparam int CHAR_GHOST4 = 4;

  // Position every character takes after reset
  localparam int DEFAULT_RESET_X = 2;
  localparam int DEFAULT_RESET_Y = 2;

  // Collision scan FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/coord_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : coord_stepper
//  Description : Combinational single-pixel step along one axis with wrap
//                between 0 and MAX in both directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module coord_stepper #(
  parameter int COORD_W = 8,
  parameter int MAX     = 159
) (
  input  logic [COORD_W-1:0] coord_i,
  input  logic               inc_i,
  output logic [COORD_W-1:0] coord_o
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

  // +1 wraps MAX -> 0, -1 wraps 0 -> MAX
  always_comb begin
    coord_o = coord_i;
    if (inc_i) begin
      coord_o = (coord_i >= MAX_C) ? '0 : coord_i + 1'b1;
    end else begin
      coord_o = (coord_i == '0) ? MAX_C : coord_i - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/character_position_file.sv
`default_nettype none
// ============================================================================
//  Module      : character_position_file
//  Description : Pixel position store for pacman (id 0) and the ghosts with
//                absolute loads, wrapping single-pixel steps, a registered
//                read port and a sequential pacman-vs-ghost tile scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module character_position_file
  import pacman_pkg::*;
#(
  parameter int NUM_CHARS  = 5,
  parameter int COORD_W    = 8,
  parameter int MAX_X      = 159,
  parameter int MAX_Y      = 119,
  parameter int RESET_X    = DEFAULT_RESET_X,
  parameter int RESET_Y    = DEFAULT_RESET_Y,
  parameter int TILE_SHIFT = 2,
  localparam int ID_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_mode,
  input  logic [ID_W-1:0]    wr_id,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [1:0]         dir_in,
  input  logic               rd_en,
  input  logic [ID_W-1:0]    rd_id,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               rd_valid,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               hit,
  output logic [ID_W-1:0]    hit_id
);

  localparam logic [COORD_W-1:0] MAX_X_C   = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C   = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0] RESET_X_C = COORD_W'(RESET_X);
  localparam logic [COORD_W-1:0] RESET_Y_C = COORD_W'(RESET_Y);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_CHARS - 1);
  localparam logic [ID_W-1:0]    FIRST_GH  = ID_W'(1);

  logic [COORD_W-1:0] x_q [NUM_CHARS];
  logic [COORD_W-1:0] y_q [NUM_CHARS];

  // Out-of-range ids are redirected to entry 0 for the array lookup; the
  // *_ok flags suppress any effect of that lookup.
  logic            wr_ok, rd_ok;
  logic [ID_W-1:0] wr_idx, rd_idx;
  assign wr_ok  = int'(wr_id) < NUM_CHARS;
  assign rd_ok  = int'(rd_id) < NUM_CHARS;
  assign wr_idx = wr_ok ? wr_id : '0;
  assign rd_idx = rd_ok ? rd_id : '0;

  logic [COORD_W-1:0] step_x, step_y, new_x, new_y;

  coord_stepper #(.COORD_W(COORD_W), .MAX(MAX_X)) u_step_x (
    .coord_i (x_q[wr_idx]),
    .inc_i   (dir_in[0]),
    .coord_o (step_x)
  );

  coord_stepper #(.COORD_W(COORD_W), .MAX(MAX_Y)) u_step_y (
    .coord_i (y_q[wr_idx]),
    .inc_i   (dir_in[0]),
    .coord_o (step_y)
  );

  // Next value for the written entry: saturating load or one-axis step
  always_comb begin
    new_x = x_q[wr_idx];
    new_y = y_q[wr_idx];
    if (!wr_mode) begin
      new_x = (x_in > MAX_X_C) ? MAX_X_C : x_in;
      new_y = (y_in > MAX_Y_C) ? MAX_Y_C : y_in;
    end else if (dir_in == DIR_LEFT || dir_in == DIR_RIGHT) begin
      new_x = step_x;
    end else begin
      new_y = step_y;
    end
  end

  // Position entries
  always_ff @(posedge clock_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        x_q[i] <= RESET_X_C;
        y_q[i] <= RESET_Y_C;
      end
    end else if (wr_en && wr_ok) begin
      x_q[wr_idx] <= new_x;
      y_q[wr_idx] <= new_y;
    end
  end

  // Registered read port; samples entries before any same-cycle write lands
  always_ff @(posedge clock_50) begin
    if (reset) begin
      x_out    <= '0;
      y_out    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        x_out <= rd_ok ? x_q[rd_idx] : '0;
        y_out <= rd_ok ? y_q[rd_idx] : '0;
      end
    end
  end

  scan_state_e        state_q, state_d;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0] pac_tx_q, pac_tx_d, pac_ty_q, pac_ty_d;
  logic               hit_q, hit_d;
  logic [ID_W-1:0]    hit_id_q, hit_id_d;

  // Scan FSM state and result registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pac_tx_q <= '0;
      pac_ty_q <= '0;
      hit_q    <= 1'b0;
      hit_id_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pac_tx_q <= pac_tx_d;
      pac_ty_q <= pac_ty_d;
      hit_q    <= hit_d;
      hit_id_q <= hit_id_d;
    end
  end

  // Scan FSM next state: one ghost compared per cycle, first match latched
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pac_tx_d = pac_tx_q;
    pac_ty_d = pac_ty_q;
    hit_d    = hit_q;
    hit_id_d = hit_id_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          pac_tx_d = x_q[CHAR_PACMAN] >> TILE_SHIFT;
          pac_ty_d = y_q[CHAR_PACMAN] >> TILE_SHIFT;
          idx_d    = FIRST_GH;
          hit_d    = 1'b0;
          hit_id_d = '0;
          state_d  = (NUM_CHARS > 1) ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        if (!hit_q && ((x_q[idx_q] >> TILE_SHIFT) == pac_tx_q) &&
            ((y_q[idx_q] >> TILE_SHIFT) == pac_ty_q)) begin
          hit_d    = 1'b1;
          hit_id_d = idx_q;
        end
        if (idx_q == LAST_ID) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign scan_busy = (state_q == ST_SCAN);
  assign scan_done = (state_q == ST_DONE);
  assign hit       = hit_q;
  assign hit_id    = hit_id_q;

endmodule
`default_nettype wire
